// File: rtl/axi4_pkg.sv
// axi4_pkg: burst/response encodings and engine state types shared by the AXI4 memory slave.
package axi4_pkg;
  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } axi4_burst_t;
  typedef logic [1:0] axi4_resp_t;
  localparam axi4_resp_t OKAY   = 2'b00;
  localparam axi4_resp_t SLVERR = 2'b10;
  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;
  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;
endpackage

// File: rtl/axi4_if.sv
// axi4_if: AXI4 full bus bundle with master and slave views.
interface axi4_if #(
  parameter int DATA_BYTES      = 4,
  parameter int ADDR_BYTES      = 1,
  parameter int NUM_ID_BITS_P   = 4,
  parameter int NUM_USER_BITS_P = 4
);
  localparam int AW = ADDR_BYTES * 8;
  localparam int DW = DATA_BYTES * 8;
  logic [NUM_ID_BITS_P-1:0]   awid;
  logic [AW-1:0]              awaddr;
  logic [7:0]                 awlen;
  logic [2:0]                 awsize;
  logic [1:0]                 awburst;
  logic [NUM_USER_BITS_P-1:0] awuser;
  logic [3:0]                 awcache;
  logic [2:0]                 awprot;
  logic                       awlock;
  logic [3:0]                 awregion;
  logic [3:0]                 awqos;
  logic                       awvalid;
  logic                       awready;
  logic [DW-1:0]              wdata;
  logic [DATA_BYTES-1:0]      wstrb;
  logic                       wlast;
  logic [NUM_USER_BITS_P-1:0] wuser;
  logic                       wvalid;
  logic                       wready;
  logic [NUM_ID_BITS_P-1:0]   bid;
  logic [1:0]                 bresp;
  logic [NUM_USER_BITS_P-1:0] buser;
  logic                       bvalid;
  logic                       bready;
  logic [NUM_ID_BITS_P-1:0]   arid;
  logic [AW-1:0]              araddr;
  logic [7:0]                 arlen;
  logic [2:0]                 arsize;
  logic [1:0]                 arburst;
  logic [NUM_USER_BITS_P-1:0] aruser;
  logic [3:0]                 arcache;
  logic [2:0]                 arprot;
  logic                       arlock;
  logic [3:0]                 arregion;
  logic [3:0]                 arqos;
  logic                       arvalid;
  logic                       arready;
  logic [NUM_ID_BITS_P-1:0]   rid;
  logic [DW-1:0]              rdata;
  logic [1:0]                 rresp;
  logic                       rlast;
  logic [NUM_USER_BITS_P-1:0] ruser;
  logic                       rvalid;
  logic                       rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awuser, awcache, awprot, awlock, awregion, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, aruser, arcache, arprot, arlock, arregion, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awuser, awcache, awprot, awlock, awregion, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, aruser, arcache, arprot, arlock, arregion, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// axi4_burst_addr_gen: next beat address for FIXED/INCR/WRAP bursts.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_BYTES = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);
  localparam logic [2:0]        LG  = 3'($clog2(DATA_BYTES));
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  logic [2:0]        sz;
  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] span;
  logic              wrap_ok;
  // Illegal WRAP lengths and the reserved burst code both fall through to INCR.
  always_comb begin
    sz        = (size > LG) ? LG : size;
    bytes     = ONE << sz;
    span      = ADDR_W'(len) * bytes + bytes;
    wrap_ok   = (burst == WRAP) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    next_addr = (burst == FIXED) ? addr :
                wrap_ok ? ((addr & ~(span - ONE)) | ((addr + bytes) & (span - ONE))) :
                ((addr & ~(bytes - ONE)) + bytes);
  end
endmodule

// File: rtl/axi4_burst_mem_slave.sv
// axi4_burst_mem_slave: AXI4 slave over an internal word memory, independent read/write burst engines.
// Define AXI4_BURST_MEM_SLVERR_EN to flag out-of-range word indices with SLVERR instead of wrapping.
module axi4_burst_mem_slave
  import axi4_pkg::*;
#(
  parameter int DATA_BYTES      = 4,
  parameter int ADDR_BYTES      = 1,
  parameter int NUM_ID_BITS_P   = 4,
  parameter int NUM_USER_BITS_P = 4,
  parameter int MEM_WORDS       = 64
) (
  input logic  aclk,
  input logic  areset,
  axi4_if.slave s
);
  localparam int AW = ADDR_BYTES * 8;
  localparam int DW = DATA_BYTES * 8;
  localparam int LG = $clog2(DATA_BYTES);
  localparam int IW = $clog2(MEM_WORDS);
  logic [DW-1:0] mem [MEM_WORDS];
  logic run_q, run_d;
  w_state_t w_state_q, w_state_d;
  logic [NUM_ID_BITS_P-1:0] aw_id_q, aw_id_d;
  logic [AW-1:0] aw_addr_q, aw_addr_d, w_next;
  logic [7:0] aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [2:0] aw_size_q, aw_size_d;
  logic [1:0] aw_burst_q, aw_burst_d;
  logic w_err_q, w_err_d, w_beat_err, w_we;
  logic [IW-1:0] w_idx;
  r_state_t r_state_q, r_state_d;
  logic [NUM_ID_BITS_P-1:0] ar_id_q, ar_id_d;
  logic [AW-1:0] ar_addr_q, ar_addr_d, r_next;
  logic [7:0] ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [2:0] ar_size_q, ar_size_d;
  logic [1:0] ar_burst_q, ar_burst_d;
  logic r_beat_err;
  logic [IW-1:0] r_idx;
  axi4_burst_addr_gen #(.ADDR_W(AW), .DATA_BYTES(DATA_BYTES)) u_wgen (
    .addr(aw_addr_q), .len(aw_len_q), .size(aw_size_q), .burst(aw_burst_q), .next_addr(w_next)
  );
  axi4_burst_addr_gen #(.ADDR_W(AW), .DATA_BYTES(DATA_BYTES)) u_rgen (
    .addr(ar_addr_q), .len(ar_len_q), .size(ar_size_q), .burst(ar_burst_q), .next_addr(r_next)
  );
  assign w_idx = aw_addr_q[LG +: IW];
  assign r_idx = ar_addr_q[LG +: IW];
`ifdef AXI4_BURST_MEM_SLVERR_EN
  assign w_beat_err = |(aw_addr_q >> (LG + IW));
  assign r_beat_err = |(ar_addr_q >> (LG + IW));
`else
  assign w_beat_err = 1'b0;
  assign r_beat_err = 1'b0;
`endif
  assign w_we = (w_state_q == W_DATA) && s.wvalid && !w_beat_err;
  // run_q keeps the address channels closed until the first edge after reset.
  always_comb begin
    run_d      = 1'b1;
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    case (w_state_q)
      W_IDLE: if (run_q && s.awvalid) begin
        aw_id_d    = s.awid;
        aw_addr_d  = s.awaddr;
        aw_len_d   = s.awlen;
        aw_size_d  = s.awsize;
        aw_burst_d = s.awburst;
        w_cnt_d    = 8'd0;
        w_err_d    = 1'b0;
        w_state_d  = W_DATA;
      end
      W_DATA: if (s.wvalid) begin
        aw_addr_d = w_next;
        w_cnt_d   = w_cnt_q + 8'd1;
        w_err_d   = w_err_q | w_beat_err;
        w_state_d = (w_cnt_q == aw_len_q) ? W_RESP : W_DATA;
      end
      W_RESP: w_state_d = s.bready ? W_IDLE : W_RESP;
      default: w_state_d = W_IDLE;
    endcase
    s.awready = run_q && (w_state_q == W_IDLE);
    s.wready  = (w_state_q == W_DATA);
    s.bvalid  = (w_state_q == W_RESP);
    s.bid     = aw_id_q;
    s.bresp   = (s.bvalid && w_err_q) ? SLVERR : OKAY;
    s.buser   = '0;
  end
  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    case (r_state_q)
      R_IDLE: if (run_q && s.arvalid) begin
        ar_id_d    = s.arid;
        ar_addr_d  = s.araddr;
        ar_len_d   = s.arlen;
        ar_size_d  = s.arsize;
        ar_burst_d = s.arburst;
        r_cnt_d    = 8'd0;
        r_state_d  = R_DATA;
      end
      R_DATA: if (s.rready) begin
        ar_addr_d = r_next;
        r_cnt_d   = r_cnt_q + 8'd1;
        r_state_d = (r_cnt_q == ar_len_q) ? R_IDLE : R_DATA;
      end
      default: r_state_d = R_IDLE;
    endcase
    s.arready = run_q && (r_state_q == R_IDLE);
    s.rvalid  = (r_state_q == R_DATA);
    s.rid     = ar_id_q;
    s.rlast   = s.rvalid && (r_cnt_q == ar_len_q);
    s.rdata   = (s.rvalid && !r_beat_err) ? mem[r_idx] : '0;
    s.rresp   = (s.rvalid && r_beat_err) ? SLVERR : OKAY;
    s.ruser   = '0;
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run_q      <= 1'b0;
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
    end else begin
      run_q      <= run_d;
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
    end
  end
  // Memory is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge aclk) begin
    if (w_we)
      for (int i = 0; i < DATA_BYTES; i++)
        if (s.wstrb[i]) mem[w_idx][i*8 +: 8] <= s.wdata[i*8 +: 8];
  end
endmodule
